layer_stream_bridge: RTL
========================

LAYER_STREAM_BRIDGE -- requirements
Module: layer_stream_bridge

Interface
REQ-001 SHALL have parameter WIDTH, default 16, FP16 word width.
REQ-002 SHALL have parameter FRAME_LEN, default 256, words per frame (2..256).
REQ-003 SHALL have parameter AW, default 8, buffer address width (2^AW >= FRAME_LEN).
REQ-004 sys_clk  input  1  clock; all logic rising-edge.
REQ-005 sys_rst  input  1  reset, asynchronous, active-high.
REQ-006 s_valid  input  1  upstream layer ovalid; one word per asserted cycle.
REQ-007 s_data  input  WIDTH  upstream layer output word.
REQ-008 m_gvalid  output  1  downstream layer weight-fetch enable.
REQ-009 m_ivalid  output  1  downstream layer input-valid.
REQ-010 m_data  output  WIDTH  word presented to the downstream layer.
REQ-011 ds_ovalid  input  1  downstream layer ovalid.
REQ-012 ds_data  input  WIDTH  downstream layer output word.
REQ-013 frame_done  output  1  one-cycle pulse when the downstream result window ends.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 overrun  output  1  sticky flag, upstream word dropped.
REQ-016 cmp_a, cmp_b  output  WIDTH each  captured result words (see Configuration).
REQ-017 cmp_valid  output  1  one-cycle pulse, cmp_a/cmp_b valid.

Function
REQ-018 SHALL implement FSM IDLE, FILL, ISSUE, WAIT.
REQ-019 IDLE: s_valid high -> word written at address 0, wr_cnt=1, go to FILL.
REQ-020 FILL: each s_valid beat written at wr_cnt, wr_cnt increments; gaps (s_valid low) allowed, no timeout.
REQ-021 FILL -> ISSUE in the cycle after the beat that makes wr_cnt == FRAME_LEN.
REQ-022 ISSUE: buffer read sequentially, one word per cycle, read latency 1 cycle.
REQ-023 m_gvalid and m_ivalid SHALL be identical, high for exactly FRAME_LEN consecutive cycles; first high cycle is 2 cycles after the last FILL beat.
REQ-024 In the k-th cycle of m_ivalid high (k = 0..FRAME_LEN-1), m_data SHALL equal the k-th word written; m_data SHALL be 0 when m_ivalid low.
REQ-025 After the last issued beat -> WAIT.
REQ-026 WAIT: on ds_ovalid falling edge (registered previous 1, current 0) -> frame_done pulse same cycle, next state IDLE.
REQ-027 ds_ovalid activity outside WAIT SHALL be ignored for frame_done.
REQ-028 s_valid in ISSUE or WAIT SHALL drop the word and set overrun; overrun clears only on reset.
REQ-029 s_valid in the cycle after frame_done (IDLE) SHALL be accepted normally.
REQ-030 Counters SHALL wrap to 0 on frame completion; no address beyond FRAME_LEN-1 is ever written.

Reset
REQ-031 sys_rst SHALL force: state IDLE, wr_cnt 0, rd_cnt 0, m_gvalid 0, m_ivalid 0, m_data 0, frame_done 0, busy 0, overrun 0, cmp_a 0, cmp_b 0, cmp_valid 0, ds_ovalid history 0.
REQ-032 Reset mid-frame SHALL abort the frame; stale buffer contents SHALL never be issued without a new complete fill.

Configuration
REQ-033 Macro LSB_RESULT_CAPTURE_EN defined: in WAIT, first ds_ovalid beat -> cmp_a, each later beat -> cmp_b (last beat wins), cmp_valid pulses with frame_done.
REQ-034 Macro LSB_RESULT_CAPTURE_EN undefined: no capture registers; cmp_a, cmp_b, cmp_valid tied 0.

Verification
REQ-035 FRAME_LEN=4, s_valid 4 contiguous beats 0x3C00,0x4000,0x4200,0x4400 -> m_ivalid high 4 cycles starting 2 cycles after last beat, m_data same order, m_gvalid identical.
REQ-036 Same frame with 1-cycle gaps between beats -> identical m_data sequence; busy high from first beat to frame_done.
REQ-037 In WAIT, ds_ovalid high 2 cycles with 0x3800 then 0x3A00, then low -> frame_done and (with macro) cmp_valid pulse, cmp_a=0x3800, cmp_b=0x3A00; without macro cmp_* stay 0.
REQ-038 s_valid asserted during ISSUE -> overrun=1, issued data unchanged; overrun stays 1 across next frame until sys_rst.
REQ-039 sys_rst asserted after 2 of 4 FILL beats, released, then 4 new beats -> only new words issued, all outputs 0 during reset.
REQ-040 Back-to-back: new frame s_valid in cycle after frame_done -> accepted, second frame issued correctly, overrun stays 0.

Source files
------------

// File: rtl/layer_stream_bridge.sv
// Buffers one upstream layer frame, replays it to the downstream layer, and waits for its result window.
// Latency: first issued word 2 cycles after the last fill beat; frame_done is combinational on the ds_ovalid fall.
// Backpressure: none; upstream words arriving while issuing or waiting are dropped and flagged in sticky overrun.
// Optional result capture of downstream words into cmp_a/cmp_b is built when LSB_RESULT_CAPTURE_EN is defined.
module layer_stream_bridge #(
  parameter int WIDTH     = 16,
  parameter int FRAME_LEN = 256,
  parameter int AW        = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_gvalid,
  output logic             m_ivalid,
  output logic [WIDTH-1:0] m_data,
  input  logic             ds_ovalid,
  input  logic [WIDTH-1:0] ds_data,
  output logic             frame_done,
  output logic             busy,
  output logic             overrun,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  output logic             cmp_valid
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_ISSUE, S_WAIT} state_t;

  localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_wr_cnt;
  logic [AW-1:0]    r_rd_cnt;
  logic [WIDTH-1:0] r_buf [0:(1<<AW)-1];
  logic             r_ivalid;
  logic [WIDTH-1:0] r_data;
  logic             r_ds_prev;
  logic             r_overrun;
  logic             w_wr_en;
  logic             w_rd_en;
  logic             w_drop;
  logic             w_frame_done;

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_en      = 1'b0;
    w_rd_en      = 1'b0;
    w_drop       = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (s_valid) begin
          w_wr_en     = 1'b1;
          w_state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        if (s_valid) begin
          w_wr_en = 1'b1;
          if (r_wr_cnt == LAST) w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_rd_en = 1'b1;
        w_drop  = s_valid;
        if (r_rd_cnt == LAST) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_drop = s_valid;
        if (r_ds_prev && !ds_ovalid) begin
          w_frame_done = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Write address: counts accepted beats, wraps to 0 when the frame is full.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)      r_wr_cnt <= '0;
    else if (w_wr_en) r_wr_cnt <= (r_wr_cnt == LAST) ? '0 : r_wr_cnt + 1'b1;
  end

  // Read address: one word per issue cycle, wraps to 0 after the last word.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)      r_rd_cnt <= '0;
    else if (w_rd_en) r_rd_cnt <= (r_rd_cnt == LAST) ? '0 : r_rd_cnt + 1'b1;
  end

  // Frame buffer write port; contents are never issued without a completed fill.
  always_ff @(posedge sys_clk) begin
    if (w_wr_en) r_buf[r_wr_cnt] <= s_data;
  end

  // Registered read port drives the downstream valid/data pair, data forced to 0 when idle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_ivalid <= 1'b0;
      r_data   <= '0;
    end else begin
      r_ivalid <= w_rd_en;
      r_data   <= w_rd_en ? r_buf[r_rd_cnt] : '0;
    end
  end

  // Downstream ovalid history for falling-edge detection.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_ds_prev <= 1'b0;
    else         r_ds_prev <= ds_ovalid;
  end

  // Sticky overrun: set by any upstream word dropped while busy replaying.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)     r_overrun <= 1'b0;
    else if (w_drop) r_overrun <= 1'b1;
  end

  assign m_gvalid   = r_ivalid;
  assign m_ivalid   = r_ivalid;
  assign m_data     = r_data;
  assign frame_done = w_frame_done;
  assign busy       = (r_state != S_IDLE);
  assign overrun    = r_overrun;

`ifdef LSB_RESULT_CAPTURE_EN
  logic             r_cap_seen;
  logic [WIDTH-1:0] r_cmp_a;
  logic [WIDTH-1:0] r_cmp_b;

  // First result beat of the window goes to cmp_a, every later beat overwrites cmp_b.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cap_seen <= 1'b0;
      r_cmp_a    <= '0;
      r_cmp_b    <= '0;
    end else if (r_state == S_WAIT) begin
      if (ds_ovalid) begin
        if (!r_cap_seen) r_cmp_a <= ds_data;
        else             r_cmp_b <= ds_data;
        r_cap_seen <= 1'b1;
      end
    end else begin
      r_cap_seen <= 1'b0;
    end
  end

  assign cmp_a     = r_cmp_a;
  assign cmp_b     = r_cmp_b;
  assign cmp_valid = w_frame_done;
`else
  logic w_unused_ds;
  assign w_unused_ds = ^ds_data;
  assign cmp_a       = '0;
  assign cmp_b       = '0;
  assign cmp_valid   = 1'b0;
`endif

endmodule
